// File: rtl/isa_pkg.sv
// Shared ISA definitions: opcodes, NOP encoding, datapath widths and fetch FSM types.
// Imported by the fetch stage and its next-PC mux.
package isa_pkg;

  localparam int PC_WIDTH    = 16;
  localparam int INSTR_WIDTH = 32;

  localparam logic [5:0] OPC_JUMP = 6'b000001;
  localparam logic [5:0] OPC_BNE  = 6'b000101;
  localparam logic [5:0] OPC_BLT  = 6'b000110;
  localparam logic [5:0] OPC_BLE  = 6'b000111;
  localparam logic [5:0] OPC_ADDI = 6'b001000;

  localparam logic [INSTR_WIDTH-1:0] NOP = '0;

  typedef enum logic [1:0] {
    ST_INIT,
    ST_RUN,
    ST_STALLED,
    ST_BUBBLE
  } fetch_state_e;

  typedef enum logic [1:0] {
    PC_HOLD,
    PC_INC,
    PC_JUMP,
    PC_REDIR
  } pc_sel_e;

endpackage

// File: rtl/next_pc_sel.sv
// Combinational next-PC mux: hold, increment (wrapping), local jump target or redirect target.
// No state; the caller decides priority through i_sel.
module next_pc_sel
  import isa_pkg::*;
#(
  parameter int W = 16
) (
  input  pc_sel_e        i_sel,
  input  logic [W-1:0]   i_pc,
  input  logic [W-1:0]   i_jump_pc,
  input  logic [W-1:0]   i_redirect_pc,
  output logic [W-1:0]   o_next_pc
);

  localparam logic [W-1:0] PC_ONE = W'(1);

  always_comb begin
    o_next_pc = i_pc;
    case (i_sel)
      PC_INC:   o_next_pc = i_pc + PC_ONE;
      PC_JUMP:  o_next_pc = i_jump_pc;
      PC_REDIR: o_next_pc = i_redirect_pc;
      default:  o_next_pc = i_pc;
    endcase
  end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: owns PC, captures Instruction into IF/ID one edge after PC presents it.
// Stall freezes PC and IF/ID; Redirect squashes the current fetch for exactly one cycle.
module instr_fetch #(
  parameter int                  PC_WIDTH    = isa_pkg::PC_WIDTH,
  parameter int                  INSTR_WIDTH = isa_pkg::INSTR_WIDTH,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = '0,
  parameter logic [5:0]          JUMP_OPCODE = isa_pkg::OPC_JUMP
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic [PC_WIDTH-1:0]    PC,
  input  logic [INSTR_WIDTH-1:0] Instruction,
  input  logic                   Stall,
  input  logic                   Redirect,
  input  logic [PC_WIDTH-1:0]    RedirectPC,
  output logic [INSTR_WIDTH-1:0] IR,
  output logic [PC_WIDTH-1:0]    IR_PC,
  output logic                   IR_Valid,
  output logic                   JumpTaken,
  output logic [31:0]            FetchCount
);

  import isa_pkg::*;

  fetch_state_e            r_state, w_state_nxt;
  pc_sel_e                 w_pc_sel;
  logic                    w_capture, w_squash, w_is_jump;
  logic [PC_WIDTH-1:0]     r_pc, w_pc_nxt;
  logic [INSTR_WIDTH-1:0]  r_ir;
  logic [PC_WIDTH-1:0]     r_ir_pc;
  logic                    r_ir_vld, r_jump;
  logic [31:0]             r_fetch_cnt;

  assign w_is_jump = (Instruction[INSTR_WIDTH-1 -: 6] == JUMP_OPCODE);

  // INIT ignores Redirect; elsewhere Redirect beats Stall beats capture.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_sel    = PC_HOLD;
    w_capture   = 1'b0;
    w_squash    = 1'b0;
    if (r_state == ST_INIT) begin
      w_state_nxt = ST_RUN;
    end else if (Redirect) begin
      w_state_nxt = ST_BUBBLE;
      w_pc_sel    = PC_REDIR;
      w_squash    = 1'b1;
    end else if (Stall) begin
      w_state_nxt = ST_STALLED;
    end else begin
      w_state_nxt = ST_RUN;
      w_capture   = 1'b1;
      w_pc_sel    = w_is_jump ? PC_JUMP : PC_INC;
    end
  end

  next_pc_sel #(.W(PC_WIDTH)) u_next_pc_sel (
    .i_sel         (w_pc_sel),
    .i_pc          (r_pc),
    .i_jump_pc     (Instruction[PC_WIDTH-1:0]),
    .i_redirect_pc (RedirectPC),
    .o_next_pc     (w_pc_nxt)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_INIT;
      r_pc        <= RESET_PC;
      r_ir        <= NOP;
      r_ir_pc     <= '0;
      r_ir_vld    <= 1'b0;
      r_jump      <= 1'b0;
      r_fetch_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_jump  <= w_capture && w_is_jump;
      if (w_squash) begin
        r_ir     <= NOP;
        r_ir_vld <= 1'b0;
      end else if (w_capture) begin
        r_ir        <= Instruction;
        r_ir_pc     <= r_pc;
        r_ir_vld    <= 1'b1;
        r_fetch_cnt <= r_fetch_cnt + 32'd1;
      end
    end
  end

  assign PC         = r_pc;
  assign IR         = r_ir;
  assign IR_PC      = r_ir_pc;
  assign IR_Valid   = r_ir_vld;
  assign JumpTaken  = r_jump;
  assign FetchCount = r_fetch_cnt;

endmodule
